// File: rtl/spi_reg_burst.sv
// SPI slave register bridge: oversampled SPI pins feed a command/data FSM that
// issues register write strobes and read requests, with burst auto-increment.
module spi_reg_burst #(
  parameter int ADDR_W     = 6,
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ena,
  input  logic [1:0]              mode,
  input  logic                    spi_clk,
  input  logic                    spi_cs_n,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  input  logic [7:0]              status,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic                    busy,
  output logic                    frame_abort
);
  localparam int REG_W = 8 * DATA_BYTES;
  localparam int CNT_W = $clog2(REG_W);

  typedef enum logic [1:0] {IDLE, CMD, LOAD, DATA} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sclk_q, csn_q;
  logic [1:0]        mosi_q;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]  rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              armed_q, armed_d, rw_q, rw_d;
  logic              we_q, we_d, re_q, re_d, abort_q, abort_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_gate, samp_on_rise;
  logic sample, change, last, word_done;
  logic [REG_W-1:0] rx_shift;

  // Index 0/1 are the synchroniser pair, index 2 is the edge-detect history.
  assign sclk_rise    = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall    = ~sclk_q[1] & sclk_q[2];
  assign cs_fall      = ~csn_q[1] & csn_q[2];
  assign cs_rise      = csn_q[1] & ~csn_q[2];
  // Edges stay live in the cs_n rise cycle so a word finishing there completes.
  assign cs_gate      = ~csn_q[1] | ~csn_q[2];
  assign samp_on_rise = (mode_q[1] == mode_q[0]);
  assign sample       = cs_gate & (samp_on_rise ? sclk_rise : sclk_fall);
  assign change       = cs_gate & (samp_on_rise ? sclk_fall : sclk_rise);
  assign rx_shift     = {rx_q[REG_W-2:0], mosi_q[1]};
  assign last         = (state_q == CMD) ? (cnt_q == CNT_W'(7)) : (cnt_q == CNT_W'(REG_W-1));
  assign word_done    = sample & last & ((state_q == CMD) | (state_q == DATA));

  always_ff @(posedge clk) begin
    if (!rstb)      state_q <= IDLE;
    else if (ena)   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD, DATA: begin
        if (cs_rise)                                            state_d = IDLE;
        else if (re_q)                                          state_d = LOAD;
        else if (word_done && state_q == CMD && rx_shift[7])    state_d = DATA;
      end
      LOAD:    state_d = cs_rise ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    armed_d = armed_q;
    rw_d    = rw_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (cs_fall) begin
        mode_d  = mode;
        tx_d    = REG_W'(status) << (REG_W - 8);
        armed_d = 1'b0;
        cnt_d   = '0;
      end
      CMD, DATA: begin
        if (sample) begin
          rx_d    = rx_shift;
          armed_d = 1'b1;
          cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        end else if (change && armed_q) begin
          tx_d = tx_q << 1;
        end
        if (word_done) begin
          if (state_q == CMD) begin
            rw_d   = rx_shift[7];
            addr_d = rx_shift[ADDR_W-1:0];
            if (rx_shift[7]) begin
              tx_d    = '0;
              armed_d = 1'b0;
            end else begin
              re_d = 1'b1;
            end
          end else if (rw_q) begin
            we_d    = 1'b1;
            wdata_d = rx_shift;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            re_d   = 1'b1;
          end
        end
        // Abort is judged on the count after this cycle's sample is applied.
        if (cs_rise) begin
          abort_d = (cnt_d != '0);
          cnt_d   = '0;
        end
      end
      LOAD: begin
        tx_d    = reg_rdata;
        armed_d = 1'b0;
      end
      default: ;
    endcase
    if (we_q) addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sclk_q  <= '0;
      csn_q   <= '1;
      mosi_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      armed_q <= 1'b0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      abort_q <= 1'b0;
    end else if (ena) begin
      sclk_q  <= {sclk_q[1:0], spi_clk};
      csn_q   <= {csn_q[1:0], spi_cs_n};
      mosi_q  <= {mosi_q[0], spi_mosi};
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      armed_q <= armed_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      re_q    <= re_d;
      abort_q <= abort_d;
    end
  end

  assign spi_miso    = ~csn_q[1] & tx_q[REG_W-1];
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q & ena;
  assign reg_re      = re_q & ena;
  assign frame_abort = abort_q & ena;
  assign busy        = (state_q != IDLE);
endmodule

// File: doc/spi_reg_burst.md
Name: spi_reg_burst

Overview:
- SPI slave register-access bridge: second generation of the team's single-byte SPI register port.
- Adds parametrised multi-byte register words, burst transfers with address auto-increment, input synchronisers, CPHA-correct MISO timing and aborted-frame reporting.
- Sits between the chip's SPI pins and the register file. All logic runs on the system clock `clk`; `spi_clk` is oversampled.

Parameters:
- ADDR_W, 6, register address width; legal range 1..7.
- DATA_BYTES, 2, bytes per register word; legal range 1..4. REG_W = 8*DATA_BYTES (derived, not overridable).

Ports:
- clk  in  1  system clock
- rstb  in  1  reset; synchronous, active-low
- ena  in  1  clock enable; when 0, all state (synchronisers included) holds
- mode  in  2  SPI mode {CPOL,CPHA}; sampled only while idle
- spi_clk  in  1  SPI clock (async)
- spi_cs_n  in  1  chip select, active-low (async)
- spi_mosi  in  1  serial data in (async)
- spi_miso  out  1  serial data out; 0 whenever synchronised cs_n is high
- status  in  8  status byte, shifted out during the command byte
- reg_addr  out  ADDR_W  current register address
- reg_wdata  out  REG_W  write data; valid with reg_we
- reg_we  out  1  one-clk write strobe
- reg_re  out  1  one-clk read request
- reg_rdata  in  REG_W  read data; must be valid 1 clk after reg_re
- busy  out  1  high while not in IDLE
- frame_abort  out  1  one-clk pulse: frame ended mid-byte/word

Behaviour:
- Reset (rstb=0 at posedge clk): state=IDLE. spi_miso, reg_addr, reg_wdata, reg_we, reg_re, busy and frame_abort all 0. Shift registers, counters and synchronisers cleared; the cs_n synchroniser resets to 1.
- Synchronisers: spi_clk, spi_cs_n and spi_mosi each pass through 2 flops, followed by an edge-detect flop. Edge pulses are 1 clk wide and appear 3 clk after the pin edge.
- Host constraint: spi_clk half-period ≥ 4 clk.
- Sample edge: rising for mode 00 and 11, falling for mode 01 and 10. Change edge is the opposite edge. Both edges are gated by synchronised cs_n=0.
- Frame format, MSB first:
  - Command byte: bit7 = rw (1 = write, 0 = read); bits[ADDR_W-1:0] = start address; remaining bits ignored.
  - Followed by any number of REG_W-bit data words.
- States:
  - IDLE: on cs_n falling → CMD. Latch mode; tx_shift ← {status, zero pad}; armed ← 0.
  - CMD: shift mosi into rx on each sample edge. On the 8th sample: latch rw and addr.
    - rw=1 → DATA.
    - rw=0 → pulse reg_re with reg_addr = addr, then → LOAD.
  - LOAD (exactly 1 clk): tx_shift ← reg_rdata; armed ← 0; → DATA.
  - DATA: shift on each sample edge. On the REG_W-th sample:
    - Write: pulse reg_we with reg_wdata = received word and reg_addr = current addr; addr increments the next clk.
    - Read: addr increments, reg_re pulses with the new addr, → LOAD.
    - Bit counter returns to 0; remain in DATA/LOAD for the next word.
- Address increment wraps modulo 2^ADDR_W (all-ones → 0). reg_addr always reflects the latched/current address.
- MISO: spi_miso = tx_shift MSB.
  - On a sample edge: armed ← 1.
  - On a change edge: shift left (fill 0) only if armed=1.
  - Effect for CPHA=0: the first bit is presented before the first sample edge. For CPHA=1: the first leading change edge does not discard the MSB.
  - Write frames: spi_miso = 0 after the command byte.
- cs_n rising in any non-IDLE state → IDLE next clk; counters cleared.
  - frame_abort pulses if the bit counter ≠ 0 (CMD byte or data word incomplete).
  - A partial word never produces reg_we.
  - Read prefetch already issued is not cancelled (read has no side effects).
- cs_n rising in the same clk as the final sample edge of a word: the word completes (reg_we issued), no frame_abort.
- Glitch: cs_n rise then fall while in IDLE starts a fresh frame normally.
- ena=0 freezes everything: no strobes, no edge detection.
- busy = (state ≠ IDLE).

Test Plan:
- Mode 0, defaults: write cmd 0x85, data 0xBEEF → exactly one reg_we with reg_addr=5, reg_wdata=0xBEEF. MISO during the cmd byte equals status=0xA5.
- Mode 3 burst write: cmd 0xBF, words 0x1111, 0x2222 → reg_we at addr 0x3F, then addr 0x00 (wrap).
- Mode 1 burst read: cmd 0x02, model returns 0x1234 at addr 2 and 0x5678 at addr 3; 32 clocks → MISO yields 0x1234 then 0x5678 with no bit lost. reg_re pulses for addrs 2, 3, 4.
- Abort: cmd 0x81, raise cs_n after 9 data bits → no reg_we, one frame_abort pulse, busy low 1 clk later.
- Mode 2 with DATA_BYTES=1, ADDR_W=3: write cmd 0x87, data 0x3C → reg_we addr=7, wdata=0x3C. A following read of addr 7 returns 0x3C on MISO.
- rstb low mid-read, then frame cmd 0x81 data 0x00AA → all outputs 0 during reset; the new frame completes correctly.
